vector_runner: RTL and testbench



---
 rtl/vector_runner_pkg.sv | 38 +++
 rtl/vector_runner_if.sv | 53 +++++
 rtl/runner_vec_mem.sv | 59 +++++
 rtl/vector_runner.sv | 234 +++++++++++++++++++++++
 tb/tb_vector_runner.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_runner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_runner_pkg
// Description : Shared types, default sizes and width helpers for the
//               vector_runner stimulus/response engine.
// Contents    : state_e    - run FSM state encoding
//               DEF_*      - default width/depth/settle values
//               addr_w()   - slot address width for a given depth
//               cnt_w()    - width of a 0..depth counter
// Revision    : 1.0 - initial release
// ============================================================================
package vector_runner_pkg;

    localparam int DEF_IN_W   = 20;
    localparam int DEF_OUT_W  = 10;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_SETTLE = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Address width of a DEPTH-entry array; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Width of a counter that must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_runner_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_runner_if
// Description : Bundle of the load, control, status, DUT-side and result-read
//               signals of vector_runner.
// Modports    : slave  - the runner (receives loads/commands, drives dut_in)
//               master - the environment (offers vectors, models the DUT)
// Signals     : load_valid/load_ready/load_stim/load_exp - vector load
//               clear/start/busy/done                    - run control
//               dut_in/dut_out                           - DUT connection
//               vec_count/mismatch_count/fail_*          - statistics
//               res_rd_addr/res_rd_data                  - result readback
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_runner_if import vector_runner_pkg::*; #(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic             load_valid;
    logic             load_ready;
    logic [IN_W-1:0]  load_stim;
    logic [OUT_W-1:0] load_exp;
    logic             clear;
    logic             start;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic [CW-1:0]    vec_count;
    logic [CW-1:0]    mismatch_count;
    logic             fail_valid;
    logic [AW-1:0]    fail_idx;
    logic [AW-1:0]    res_rd_addr;
    logic [OUT_W-1:0] res_rd_data;

    modport slave (
        input  load_valid, load_stim, load_exp, clear, start, dut_out, res_rd_addr,
        output load_ready, busy, done, dut_in, vec_count, mismatch_count,
               fail_valid, fail_idx, res_rd_data
    );

    modport master (
        output load_valid, load_stim, load_exp, clear, start, dut_out, res_rd_addr,
        input  load_ready, busy, done, dut_in, vec_count, mismatch_count,
               fail_valid, fail_idx, res_rd_data
    );

endinterface
`default_nettype wire

// File: rtl/runner_vec_mem.sv
`default_nettype none
// ============================================================================
// Module      : runner_vec_mem
// Description : Register-array vector storage, one synchronous write port and
//               two combinational read ports. RESET_EN selects whether the
//               array is cleared by rst.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               we_i/wr_addr_i/wr_data_i - write port
//               rd_addr_a_i/rd_data_a_o  - read port A
//               rd_addr_b_i/rd_data_b_o  - read port B
// Revision    : 1.0 - initial release
// ============================================================================
module runner_vec_mem import vector_runner_pkg::*; #(
    parameter int WIDTH    = DEF_OUT_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit RESET_EN = 1'b0
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       we_i,
    input  wire logic [addr_w(DEPTH)-1:0]   wr_addr_i,
    input  wire logic [WIDTH-1:0]           wr_data_i,
    input  wire logic [addr_w(DEPTH)-1:0]   rd_addr_a_i,
    output logic      [WIDTH-1:0]           rd_data_a_o,
    input  wire logic [addr_w(DEPTH)-1:0]   rd_addr_b_i,
    output logic      [WIDTH-1:0]           rd_data_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    generate
        if (RESET_EN) begin : g_rst
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (we_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
            end
        end else begin : g_no_rst
            // Contents are deliberately left untouched by rst.
            logic unused_rst;
            assign unused_rst = rst;

            always_ff @(posedge clk) begin
                if (we_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
            end
        end
    endgenerate

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule
`default_nettype wire

// File: rtl/vector_runner.sv
`default_nettype none
// ============================================================================
// Module      : vector_runner
// Description : Buffers up to DEPTH stimulus/expected pairs, plays them onto
//               a combinational DUT one at a time, samples the response after
//               SETTLE extra cycles, stores it and counts mismatches.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - vector_runner_if.slave (load, control, status, DUT
//                      drive/response and result readback)
// Revision    : 1.0 - initial release
// ============================================================================
module vector_runner import vector_runner_pkg::*; #(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vector_runner_if.slave   bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [SW-1:0] c_SETTLE_LAST = (SETTLE > 0) ? SW'(SETTLE - 1) : '0;
    localparam logic [CW-1:0] c_FULL        = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    vec_count_q;
    logic [CW-1:0]    vec_count_d;
    logic [AW-1:0]    idx_q;
    logic [SW-1:0]    settle_cnt_q;
    logic [CW-1:0]    mismatch_q;
    logic             fail_valid_q;
    logic [AW-1:0]    fail_idx_q;
    logic [IN_W-1:0]  dut_in_q;

    logic             load_fire;
    logic             store_we;
    logic             cap_we;
    logic             resp_bad;
    logic             last_vec;
    logic [IN_W-1:0]  stim_rd;
    logic [OUT_W-1:0] exp_rd;

    logic [IN_W-1:0]  unused_stim_b;
    logic [OUT_W-1:0] unused_exp_b;
    logic [OUT_W-1:0] unused_res_b;

    // ------------------------------------------------------------------
    // Load path and buffer occupancy
    // ------------------------------------------------------------------
    assign bus.load_ready = (state_q == ST_IDLE) && (vec_count_q != c_FULL);
    assign load_fire      = bus.load_valid && bus.load_ready;
    // A clear in the same cycle discards the pair, so skip the write too.
    assign store_we       = load_fire && !bus.clear;

    // The count only moves in IDLE; during a run it is the run length.
    always_comb begin
        vec_count_d = vec_count_q;
        if (state_q == ST_IDLE) begin
            if (bus.clear) begin
                vec_count_d = '0;
            end else if (load_fire) begin
                vec_count_d = vec_count_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector storage
    // ------------------------------------------------------------------
    runner_vec_mem #(
        .WIDTH    (IN_W),
        .DEPTH    (DEPTH),
        .RESET_EN (1'b0)
    ) u_stim_mem (
        .clk         (clk),
        .rst         (rst),
        .we_i        (store_we),
        .wr_addr_i   (vec_count_q[AW-1:0]),
        .wr_data_i   (bus.load_stim),
        .rd_addr_a_i (idx_q),
        .rd_data_a_o (stim_rd),
        .rd_addr_b_i (bus.res_rd_addr),
        .rd_data_b_o (unused_stim_b)
    );

    runner_vec_mem #(
        .WIDTH    (OUT_W),
        .DEPTH    (DEPTH),
        .RESET_EN (1'b0)
    ) u_exp_mem (
        .clk         (clk),
        .rst         (rst),
        .we_i        (store_we),
        .wr_addr_i   (vec_count_q[AW-1:0]),
        .wr_data_i   (bus.load_exp),
        .rd_addr_a_i (idx_q),
        .rd_data_a_o (exp_rd),
        .rd_addr_b_i (bus.res_rd_addr),
        .rd_data_b_o (unused_exp_b)
    );

    runner_vec_mem #(
        .WIDTH    (OUT_W),
        .DEPTH    (DEPTH),
        .RESET_EN (1'b1)
    ) u_res_mem (
        .clk         (clk),
        .rst         (rst),
        .we_i        (cap_we),
        .wr_addr_i   (idx_q),
        .wr_data_i   (bus.dut_out),
        .rd_addr_a_i (bus.res_rd_addr),
        .rd_data_a_o (bus.res_rd_data),
        .rd_addr_b_i (idx_q),
        .rd_data_b_o (unused_res_b)
    );

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    assign cap_we   = (state_q == ST_CAPTURE);
    assign resp_bad = (bus.dut_out != exp_rd);
    assign last_vec = ((CW'(idx_q) + CW'(1)) == vec_count_q);

    // ------------------------------------------------------------------
    // Run FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vec_count_q  <= '0;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            mismatch_q   <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
            dut_in_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            vec_count_q <= vec_count_d;

            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx_q        <= '0;
                        mismatch_q   <= '0;
                        fail_valid_q <= 1'b0;
                        fail_idx_q   <= '0;
                        // Run length includes a same-cycle load and honours
                        // a same-cycle clear.
                        if (vec_count_d != '0) begin
                            state_q <= ST_DRIVE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_DRIVE: begin
                    dut_in_q <= stim_rd;
                    if (SETTLE > 0) begin
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == c_SETTLE_LAST) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SW'(1);
                    end
                end

                ST_CAPTURE: begin
                    if (resp_bad) begin
                        mismatch_q <= mismatch_q + CW'(1);
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_idx_q   <= idx_q;
                        end
                    end
                    if (last_vec) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= ST_DRIVE;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.dut_in         = dut_in_q;
    assign bus.vec_count      = vec_count_q;
    assign bus.mismatch_count = mismatch_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.fail_idx       = fail_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_runner.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_runner
// Description : Self-checking bench for vector_runner. The modelled DUT is
//               dut_out = dut_in[9:0]. Each run pushes its expected statistics
//               into a queue that a monitor pops on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_runner;
    import vector_runner_pkg::*;

    localparam int IN_W   = 20;
    localparam int OUT_W  = 10;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 1;
    localparam int PER    = SETTLE + 2;
    localparam int LIMIT  = 400;

    typedef struct {
        int busy_cycles;
        int mism;
        int fv;
        int fidx;
    } run_exp_t;

    logic     clk = 1'b0;
    logic     rst;
    run_exp_t sb_q[$];
    int       checks = 0;
    int       errors = 0;
    int       mon_busy = 0;

    always #5 clk = ~clk;

    vector_runner_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) vif();

    vector_runner #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    // Combinational DUT model.
    assign vif.dut_out = vif.dut_in[OUT_W-1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: counts busy cycles and scores every done pulse.
    // ------------------------------------------------------------------
    initial begin
        run_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                mon_busy = 0;
            end else begin
                if (vif.busy === 1'b1) mon_busy++;
                if (vif.done === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("run_busy_cycles", mon_busy, e.busy_cycles);
                        check("run_mismatch_count", 32'(vif.mismatch_count), e.mism);
                        check("run_fail_valid", 32'(vif.fail_valid), e.fv);
                        check("run_fail_idx", 32'(vif.fail_idx), e.fidx);
                    end
                    mon_busy = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (enter and leave just after a falling edge)
    // ------------------------------------------------------------------
    task automatic load_pair(input int stim, input int exp);
        vif.load_valid = 1'b1;
        vif.load_stim  = IN_W'(stim);
        vif.load_exp   = OUT_W'(exp);
        @(negedge clk);
        vif.load_valid = 1'b0;
    endtask

    task automatic do_clear();
        vif.clear = 1'b1;
        @(negedge clk);
        vif.clear = 1'b0;
    endtask

    task automatic read_res(input int addr, input int exp, input string name);
        vif.res_rd_addr = 4'(addr);
        #1;
        check(name, 32'(vif.res_rd_data), exp);
    endtask

    // Issues start, optionally keeps start/clear asserted while busy, and
    // checks that done arrives N*(SETTLE+2)+1 cycles after the start edge.
    task automatic run(input int n, input int mism, input int fv, input int fidx, input bit hold);
        run_exp_t e;
        int c;
        e.busy_cycles = n * PER;
        e.mism        = mism;
        e.fv          = fv;
        e.fidx        = fidx;
        sb_q.push_back(e);
        vif.start = 1'b1;
        @(negedge clk);
        c = 1;
        vif.load_valid = 1'b0;
        vif.start      = hold;
        vif.clear      = hold;
        while (vif.done !== 1'b1 && c < LIMIT) begin
            if (hold && c == 2) check("load_ready_while_busy", 32'(vif.load_ready), 32'd0);
            @(negedge clk);
            c++;
        end
        vif.start = 1'b0;
        vif.clear = 1'b0;
        if (c >= LIMIT) check("done_timeout", 32'd0, 32'd1);
        else            check("done_latency", c, n * PER + 1);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int s;
        int seen;

        rst             = 1'b1;
        vif.load_valid  = 1'b0;
        vif.load_stim   = '0;
        vif.load_exp    = '0;
        vif.clear       = 1'b0;
        vif.start       = 1'b0;
        vif.res_rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(vif.busy), 32'd0);
        check("rst_done", 32'(vif.done), 32'd0);
        check("rst_load_ready", 32'(vif.load_ready), 32'd1);
        check("rst_vec_count", 32'(vif.vec_count), 32'd0);
        check("rst_mismatch_count", 32'(vif.mismatch_count), 32'd0);
        check("rst_fail_valid", 32'(vif.fail_valid), 32'd0);
        check("rst_fail_idx", 32'(vif.fail_idx), 32'd0);
        check("rst_dut_in", 32'(vif.dut_in), 32'd0);
        read_res(0, 0, "rst_res0");
        read_res(15, 0, "rst_res15");

        // Three matching vectors
        load_pair('h00001, 'h001);
        load_pair('h00002, 'h002);
        load_pair('h00003, 'h003);
        check("t1_vec_count", 32'(vif.vec_count), 32'd3);
        run(3, 0, 0, 0, 1'b0);
        read_res(0, 'h001, "t1_res0");
        read_res(1, 'h002, "t1_res1");
        read_res(2, 'h003, "t1_res2");
        check("t1_dut_in_hold", 32'(vif.dut_in), 32'h3);

        // One bad expected value, then a replay of the same buffer
        do_clear();
        load_pair('h00001, 'h001);
        load_pair('h00002, 'h3FF);
        load_pair('h00003, 'h003);
        run(3, 1, 1, 1, 1'b0);
        read_res(1, 'h002, "t2_res1");
        run(3, 1, 1, 1, 1'b0);

        // Fill to capacity; the 17th offer must be refused
        do_clear();
        for (int i = 0; i < 17; i++) begin
            check("t3_load_ready", 32'(vif.load_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            s = 'h12300 + i;
            load_pair(s, s & 'h3FF);
        end
        check("t3_vec_count", 32'(vif.vec_count), 32'd16);
        run(DEPTH, 0, 0, 0, 1'b0);
        read_res(0, 'h300, "t3_res0");
        read_res(15, 'h30F, "t3_res15");

        // Empty run, then start with a same-cycle load
        do_clear();
        run(0, 0, 0, 0, 1'b0);
        vif.load_valid = 1'b1;
        vif.load_stim  = 20'hABCDE;
        vif.load_exp   = 10'h0DE;
        run(1, 0, 0, 0, 1'b0);
        check("t4_vec_count", 32'(vif.vec_count), 32'd1);
        read_res(0, 'h0DE, "t4_res0");

        // Reset while the third vector is being driven
        do_clear();
        load_pair('h00001, 'h001);
        load_pair('h00002, 'h002);
        load_pair('h00003, 'h003);
        vif.start = 1'b1;
        @(negedge clk);
        vif.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(vif.busy), 32'd0);
        check("t5_vec_count", 32'(vif.vec_count), 32'd0);
        check("t5_dut_in", 32'(vif.dut_in), 32'd0);
        check("t5_done", 32'(vif.done), 32'd0);
        read_res(0, 0, "t5_res0_cleared");
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vif.done === 1'b1) seen++;
        end
        check("t5_no_done", seen, 32'd0);

        // start/clear held high during a run are ignored
        load_pair('h00011, 'h011);
        load_pair('h00022, 'h022);
        load_pair('h00033, 'h033);
        run(3, 0, 0, 0, 1'b1);
        check("t6_vec_count_kept", 32'(vif.vec_count), 32'd3);
        read_res(2, 'h033, "t6_res2");
        do_clear();
        check("t6_vec_count_cleared", 32'(vif.vec_count), 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
